// File: rtl/memory_sp_req_ctrl_if.sv
// memory_if: single-port memory bus between a request controller (src) and
// a memory with a one-cycle flopped read (dst). read_data is valid the cycle
// after a read enable.
interface memory_if #(
    parameter int  AW     = 1,
    parameter type data_t = logic [1:0]
);
    logic          enable;
    logic          wr_en;
    logic [AW-1:0] addr;
    data_t         write_data;
    data_t         read_data;

    modport src (
        output enable,
        output wr_en,
        output addr,
        output write_data,
        input  read_data
    );

    modport dst (
        input  enable,
        input  wr_en,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/memory_sp_req_ctrl.sv
// memory_sp_req_ctrl: turns a ready/valid request stream into single-port
// memory strobes, tracks the one-cycle read latency, buffers responses in a
// small FIFO and throttles reads with credits so the FIFO can never overflow.
// Out-of-range reads answer with err=1/data=0 without touching the memory;
// out-of-range writes are dropped.
// Optional feature macro: MEM_REQ_WR_ACK_EN -- when defined every accepted
// write also returns a response (data=0, err=out-of-range) and writes consume
// credit like reads.
module memory_sp_req_ctrl #(
    parameter int  DEPTH     = 2,
    parameter type data_t    = logic [1:0],
    parameter int  ADDR_W    = 1,
    parameter int  RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  data_t             req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output data_t             rsp_data,
    output logic              rsp_err,
    memory_if.src             mem_port
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

`ifdef MEM_REQ_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    logic             acc;
    logic             inRange;
    logic             creditOk;
    logic             pushEn;
    logic             popEn;
    data_t            pushData;
    logic             pushErr;

    logic             inflight_q;
    logic             pendWr_q;
    logic             oob_q;

    logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    data_t            dataMem_q [RSP_DEPTH];
    logic             errMem_q  [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (32'(p) == 32'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign inRange = 32'(req_addr) < 32'(DEPTH);

    // Credit counts buffered responses plus the one still coming back from
    // memory; a same-cycle pop is deliberately ignored so rsp_ready never
    // reaches req_ready combinationally.
    always_comb begin
        creditOk  = (32'(fifoCount_q) + 32'(inflight_q)) < 32'(RSP_DEPTH);
        req_ready = rst_n && ((req_wr && !WR_ACK) || creditOk);
        acc       = req_valid && req_ready;
    end

    assign mem_port.enable     = acc && inRange;
    assign mem_port.wr_en      = req_wr;
    assign mem_port.addr       = MEM_AW'(req_addr);
    assign mem_port.write_data = req_data;

    // Remember what was accepted last cycle so its response can be formed
    // once the memory's flopped read data is available.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            pendWr_q   <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            inflight_q <= acc && (!req_wr || WR_ACK);
            pendWr_q   <= req_wr;
            oob_q      <= !inRange;
        end
    end

    assign pushEn   = inflight_q;
    assign pushData = (pendWr_q || oob_q) ? '0 : mem_port.read_data;
    assign pushErr  = oob_q;

    assign rsp_valid = rst_n && (fifoCount_q != '0);
    assign rsp_data  = rsp_valid ? dataMem_q[rdPtr_q] : '0;
    assign rsp_err   = rsp_valid && errMem_q[rdPtr_q];
    assign popEn     = rsp_valid && rsp_ready;

    // Next-state for the FIFO pointers and occupancy; push+pop cancels out.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fifoCount_d = fifoCount_q;
        if (pushEn) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (popEn) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        case ({pushEn, popEn})
            2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
            2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    // FIFO control registers; reset drops every buffered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifoCount_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            fifoCount_q <= fifoCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
        end
    end

    // FIFO storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            dataMem_q[wrPtr_q] <= pushData;
            errMem_q[wrPtr_q]  <= pushErr;
        end
    end

    assertNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pushEn && (32'(fifoCount_q) == 32'(RSP_DEPTH))));

    assertEnableInRange: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_port.enable && !inRange));

endmodule

// File: tb/tb_memory_sp_req_ctrl.sv
// tb_memory_sp_req_ctrl: DUT with DEPTH=4, ADDR_W=3, RSP_DEPTH=3, a flopped
// read memory model, a directed vector table, hand-written corner sequences
// and a randomized phase checked against a queue-based reference model.
module tb_memory_sp_req_ctrl;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 3;
    localparam int RSP_DEPTH = 3;
    localparam int MEM_AW    = 2;

`ifdef MEM_REQ_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    typedef logic [1:0] word_t;

    typedef struct packed {
        word_t data;
        logic  err;
    } rsp_t;

    typedef struct {
        logic              v;
        logic              w;
        logic [ADDR_W-1:0] a;
        word_t             d;
        logic              rr;
        logic              eRdy;
        logic              eEn;
        logic              eVal;
        word_t             eData;
        logic              eErr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    word_t             req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    word_t             rsp_data;
    logic              rsp_err;

    int    checks   = 0;
    int    failures = 0;
    rsp_t  expQ [$];
    word_t refMem [DEPTH];
    word_t memArr [DEPTH];
    vec_t  vecs [16];
    logic  monReady;
    logic  monInRange;
    rsp_t  monHead;

    always #5 clk = ~clk;

    memory_if #(.AW(MEM_AW), .data_t(word_t)) memIf ();

    memory_sp_req_ctrl #(
        .DEPTH(DEPTH), .data_t(word_t), .ADDR_W(ADDR_W), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_port(memIf)
    );

    // Single-port memory with a flopped read; cleared by reset so the
    // reference copy can start from known contents.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) memArr[i] <= '0;
        end else if (memIf.enable) begin
            if (memIf.wr_en) memArr[memIf.addr] <= memIf.write_data;
            else             memIf.read_data <= memArr[memIf.addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                                 input word_t d, input logic rr);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_data  = d;
        rsp_ready = rr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: outstanding responses are a queue in request order,
    // the memory is a plain array, and credit is the queue length.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        end else begin
            monReady   = (req_wr && !WR_ACK) || (expQ.size() < RSP_DEPTH);
            monInRange = int'(req_addr) < DEPTH;
            checkOutput("model_req_ready", 32'(req_ready), 32'(monReady));
            checkOutput("model_mem_enable", 32'(memIf.enable), 32'(req_valid && monReady && monInRange));
            if (rsp_valid) begin
                checkOutput("model_rsp_pending", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    monHead = expQ[0];
                    checkOutput("model_rsp_data", 32'(rsp_data), 32'(monHead.data));
                    checkOutput("model_rsp_err", 32'(rsp_err), 32'(monHead.err));
                    if (rsp_ready) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("model_idle_outputs", 32'({rsp_data, rsp_err}), 32'd0);
            end
            if (req_valid && monReady) begin
                if (!req_wr) begin
                    expQ.push_back(monInRange ? rsp_t'{data: refMem[req_addr[1:0]], err: 1'b0}
                                              : rsp_t'{data: 2'd0, err: 1'b1});
                end else begin
                    if (monInRange) refMem[req_addr[1:0]] = req_data;
                    if (WR_ACK) expQ.push_back(rsp_t'{data: 2'd0, err: !monInRange});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted;
        int seen;
        int waited;

        vecs[0]  = '{1'b1, 1'b1, 3'd2, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 3'd1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'd3, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd3, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'd7, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);

        // Reset state with a request pending: nothing may be accepted.
        #1;
        applyStimulus(1'b1, 1'b1, 3'd2, 2'd3, 1'b1);
        #2;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data_err", 32'({rsp_data, rsp_err}), 32'd0);
        checkOutput("reset_mem_enable", 32'(memIf.enable), 32'd0);

        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 3'd0, 2'd0, 1'b1);
        #2;
        checkOutput("idle_req_ready_wr", 32'(req_ready), 32'd1);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_mem_enable", 32'(memIf.enable), 32'd0);

`ifndef MEM_REQ_WR_ACK_EN
        // Directed vectors: write/read latency, back-to-back reads, out-of-range.
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            applyStimulus(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rr);
            #2;
            checkOutput($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].eRdy));
            checkOutput($sformatf("vec%0d_mem_enable", i), 32'(memIf.enable), 32'(vecs[i].eEn));
            checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].eVal));
            checkOutput($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].eData));
            checkOutput($sformatf("vec%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].eErr));
        end

        // Backpressure: only RSP_DEPTH reads fit, writes still flow.
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 3'(accepted), 2'd0, 1'b0);
            #2;
            if (req_ready) accepted++;
        end
        checkOutput("bp_read_accepts", 32'(accepted), 32'd3);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 3'd0, 2'd2, 1'b0);
        #2;
        checkOutput("bp_write_ready", 32'(req_ready), 32'd1);
        checkOutput("bp_write_enable", 32'(memIf.enable), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd1, 2'd0, 1'b0);
        #2;
        checkOutput("bp_read_blocked", 32'(req_ready), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
            #2;
            if (rsp_valid) seen++;
        end
        checkOutput("bp_drained", 32'(seen), 32'd3);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd0, 2'd0, 1'b1);
        #2;
        checkOutput("bp_read_resumes", 32'(req_ready), 32'd1);
`else
        // Write acknowledge: one zero-data response per write, writes stall on credit.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 3'd1, 2'd1, 1'b0);
        #2;
        checkOutput("ack_write_ready", 32'(req_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        nextCycle();
        #2;
        checkOutput("ack_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("ack_rsp_data_err", 32'({rsp_data, rsp_err}), 32'd0);
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b1, 3'(i), 2'd3, 1'b0);
            #2;
            if (req_ready) accepted++;
        end
        checkOutput("ack_write_accepts", 32'(accepted), 32'd2);
        checkOutput("ack_write_stalled", 32'(req_ready), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
            #2;
            if (rsp_valid) seen++;
        end
        checkOutput("ack_drained", 32'(seen), 32'd3);
`endif

        // Reset mid-operation with two responses buffered and one read inflight.
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b0, 3'(i), 2'd0, 1'b0);
            #2;
            checkOutput($sformatf("rst_seq_read%0d_ready", i), 32'(req_ready), 32'd1);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'd2, 2'd0, 1'b0);
        #2;
        checkOutput("rst_seq_buffered", 32'(rsp_valid), 32'd1);
        checkOutput("rst_seq_read2_ready", 32'(req_ready), 32'd1);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
        #2;
        checkOutput("rst_seq_valid_in_reset", 32'(rsp_valid), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #2;
            checkOutput($sformatf("rst_seq_no_stale%0d", i), 32'(rsp_valid), 32'd0);
            nextCycle();
        end

        // Randomized traffic checked by the reference model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0));
            nextCycle();
        end

        // Drain everything still outstanding, bounded.
        applyStimulus(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
        waited = 0;
        while ((expQ.size() != 0 || rsp_valid) && waited < 20) begin
            nextCycle();
            waited++;
        end
        #2;
        checkOutput("drain_model_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_sp_req_ctrl.md
Name: memory_sp_req_ctrl

Overview:
- Initiator-side controller for the single-port memory interface: drives memory_if.src toward a single-cycle flopped-read memory.
- Converts a ready/valid request stream (read/write, addr, data) into memory port strobes.
- Tracks the one-cycle read latency, buffers read data in a response FIFO, and applies backpressure through credits.
- Sits between client logic (DMA, table walkers) and the memory, so clients never see memory timing directly.

Parameters:
- DEPTH, 2, number of memory words; addresses >= DEPTH are out of range.
- data_t, logic [1:0], memory word type.
- ADDR_W, 1, request address width; must be >= $clog2(DEPTH).
- RSP_DEPTH, 3, response FIFO entries; legal range 1..16; full throughput requires >= 3.

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_data  input  $size(data_t)  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  output  $size(data_t)  read data; 0 on error.
- rsp_err  output  1  1 = out-of-range access.
- mem_port  memory_if.src  -  enable, wr_en, addr, write_data out; read_data in (valid the cycle after a read enable).

Behaviour:
- Reset: rst_n is synchronous and active-low.
  - While rst_n=0: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_port.enable=0, FIFO emptied, inflight cleared.
  - Reset mid-operation discards any inflight read and all buffered responses; no response is produced for them.
- Accept: acc = req_valid && req_ready.
  - In range (req_addr < DEPTH): mem_port.enable=acc and wr_en=req_wr, combinational, same cycle; addr = req_addr truncated to the memory address width; write_data = req_data.
  - Out of range: enable stays 0.
- Credit:
  - credit_ok = (fifo_count + inflight_q) < RSP_DEPTH.
  - req_ready = rst_n && (req_wr ? 1 : credit_ok).
  - A pop in the same cycle does not free credit; there is no combinational rsp_ready -> req_ready path.
- Inflight register: inflight_q <= acc && !req_wr; also register oob_q.
  - Cycle after an in-range read: capture mem_port.read_data into the FIFO.
  - Cycle after an out-of-range read: push data=0, err=1 into the FIFO. The memory is not touched.
- Out-of-range write: dropped silently; no memory access and no response.
- FIFO: registered output.
  - Read accept in cycle N -> rsp_valid in cycle N+2 when the FIFO was empty.
  - Responses are delivered in request order.
  - rsp_data and rsp_err are held stable while rsp_valid && !rsp_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - The FIFO never overflows, guaranteed by credit; an overflow is an assertion failure.
- Throughput: with rsp_ready=1 and RSP_DEPTH >= 3, one read per cycle is sustained. Writes are always one per cycle.
- Write followed by a read of the same address in the next cycle returns the new data, since the memory write commits at posedge.
- Assertions:
  - No push when full.
  - mem_port.enable never asserted when req_addr >= DEPTH.

Optional Feature:
- MEM_REQ_WR_ACK_EN
- Defined:
  - Every accepted write also pushes a response with rsp_data=0; rsp_err=1 if the write was out of range.
  - Writes then consume credit: req_ready = rst_n && credit_ok for all requests.
- Undefined: writes produce no response and are never backpressured, as described above.

Test Plan:
- Reset then idle, DEPTH=4 -> req_ready=1 for writes, rsp_valid=0, mem_port.enable=0; write 0x3 @2 then read @2 -> rsp_data=0x3, rsp_err=0, rsp_valid exactly 2 cycles after read accept.
- Back-to-back reads @0..3 with rsp_ready=1, RSP_DEPTH=3 -> 4 accepts in 4 cycles, responses in order with no bubbles.
- rsp_ready=0, issue 5 reads -> exactly 3 accepted, then req_ready=0 for reads while writes are still accepted; raise rsp_ready -> 3 responses drain, then reads resume.
- Read @7 with DEPTH=4 -> no mem_port.enable, response rsp_data=0, rsp_err=1; write @7 -> no enable, no response.
- Assert rst_n=0 the cycle after a read accept with 2 responses buffered -> next cycle rsp_valid=0; after release, no stale response ever appears.
- With MEM_REQ_WR_ACK_EN: write 0x1 @1 -> one response with data=0, err=0; with rsp_ready=0 a 4th write stalls at RSP_DEPTH=3.
